// File: rtl/data_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_arb_pkg
//  Brief    : Shared types and constants for the data-port arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package data_arb_pkg;

  // Identifies which requester issued an accepted address phase.
  typedef logic master_id_t;

  // Arbiter state: no latched selection, or a selection waiting for grant.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // Arbitration policy selectors for the ARB_MODE parameter.
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage : data_arb_pkg
`default_nettype wire

// File: rtl/data_port_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : id_fifo
//  Brief    : In-order FIFO of master IDs for outstanding memory requests.
//             Pointers wrap modulo DEPTH; the occupancy count is kept
//             separately so non-power-of-two depths work.
//  Revision : 1.0 - initial release
// ============================================================================
module id_fifo
  import data_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  master_id_t       push_id_i,
  input  logic             pop_i,
  output master_id_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  master_id_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state pointers and occupancy; push and pop advance independently.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards every stored ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

endmodule : id_fifo
`default_nettype wire

// File: rtl/data_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_port_arbiter
//  Brief    : Two-master arbiter for the data-memory port (LSU = m0,
//             trace/debug = m1). Arbitrates the address phase, holds the
//             choice until granted, and routes responses back in order.
//  Revision : 1.0 - initial release
// ============================================================================
module data_port_arbiter
  import data_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ARB_MODE        = ARB_RR,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  m1_err_o,
  output logic                  s_req_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_rdata_i,
  input  logic                  s_err_i,
  output logic [3:0]            outstanding_o,
  output logic                  protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t       state_q, state_d;
  master_id_t       sel_q, sel_d;
  master_id_t       sel_idle;
  master_id_t       sel;
  master_id_t       fifo_head;
  logic             rr_next_q, rr_next_d;
  logic             perr_q, perr_d;
  logic             sel_req;
  logic             grant;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Fresh selection when nothing is held: fixed priority or round-robin tie-break.
  always_comb begin
    if (m0_req_i && m1_req_i) begin
      sel_idle = (ARB_MODE == ARB_RR) ? rr_next_q : 1'b0;
    end else begin
      sel_idle = m1_req_i;
    end
  end

  // A held selection cannot be preempted, which keeps s_* stable until grant.
  assign sel     = (state_q == ARB_HOLD) ? sel_q : sel_idle;
  assign sel_req = sel ? m1_req_i : m0_req_i;

  // Full FIFO masks the request without consulting rvalid, so a same-cycle
  // pop never unblocks the push. Reset also masks the combinational paths.
  assign s_req_o   = rst_ni & ~fifo_full & sel_req;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  assign grant    = s_req_o & s_gnt_i;
  assign m0_gnt_o = grant & ~sel;
  assign m1_gnt_o = grant & sel;

  // Responses return in grant order to the master at the FIFO head.
  assign pop         = rst_ni & s_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = pop & ~fifo_head;
  assign m1_rvalid_o = pop & fifo_head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign m0_err_o    = m0_rvalid_o & s_err_i;
  assign m1_err_o    = m1_rvalid_o & s_err_i;

  assign outstanding_o  = 4'(fifo_count);
  assign protocol_err_o = perr_q;

  // Arbiter FSM, round-robin pointer and sticky protocol error next-state.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_next_d = rr_next_q;
    perr_d    = perr_q | (s_rvalid_i & fifo_empty);
    case (state_q)
      ARB_IDLE: begin
        if (s_req_o && !s_gnt_i) begin
          state_d = ARB_HOLD;
          sel_d   = sel;
        end
      end
      ARB_HOLD: begin
        // Leave on grant, or if the held master abandons its request.
        if (grant || !sel_req) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (grant && (ARB_MODE == ARB_RR)) begin
      rr_next_d = ~sel;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      sel_q     <= 1'b0;
      rr_next_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_next_q <= rr_next_d;
      perr_q    <= perr_d;
    end
  end

  id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule : data_port_arbiter
`default_nettype wire

// File: tb/tb_data_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_port_arbiter
//  Brief    : Self-checking bench for data_port_arbiter (round-robin and
//             fixed-priority instances sharing one stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_port_arbiter;
  import data_arb_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        s_gnt, s_rvalid, s_err;
  logic [31:0] s_rdata;

  logic        rr_m0_gnt, rr_m0_rvalid, rr_m0_err, rr_m1_gnt, rr_m1_rvalid, rr_m1_err;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic        rr_s_req, rr_s_we, rr_perr;
  logic [3:0]  rr_s_be, rr_outst;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic        fp_s_req, fp_s_we, fp_perr;
  logic [3:0]  fp_s_be, fp_outst;

  data_port_arbiter #(.MAX_OUTSTANDING(DEPTH), .ARB_MODE(ARB_RR), .ADDR_WIDTH(32)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(rr_m0_gnt), .m0_rvalid_o(rr_m0_rvalid), .m0_rdata_o(rr_m0_rdata), .m0_err_o(rr_m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(rr_m1_gnt), .m1_rvalid_o(rr_m1_rvalid), .m1_rdata_o(rr_m1_rdata), .m1_err_o(rr_m1_err),
    .s_req_o(rr_s_req), .s_addr_o(rr_s_addr), .s_we_o(rr_s_we), .s_be_o(rr_s_be), .s_wdata_o(rr_s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
    .outstanding_o(rr_outst), .protocol_err_o(rr_perr)
  );

  data_port_arbiter #(.MAX_OUTSTANDING(DEPTH), .ARB_MODE(ARB_FIXED), .ADDR_WIDTH(32)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata), .m0_err_o(fp_m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata), .m1_err_o(fp_m1_err),
    .s_req_o(fp_s_req), .s_addr_o(fp_s_addr), .s_we_o(fp_s_we), .s_be_o(fp_s_be), .s_wdata_o(fp_s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
    .outstanding_o(fp_outst), .protocol_err_o(fp_perr)
  );

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = '0;
    m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_be = 4'hF; m1_wdata = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_err = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 4 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    total++; if ({rr_m1_gnt, rr_m0_gnt, rr_m1_rvalid, rr_m0_rvalid} !== 4'b0000) begin
      bad++; $display("FAIL reset_rr_gnt_rvalid got=%b want=0000", {rr_m1_gnt, rr_m0_gnt, rr_m1_rvalid, rr_m0_rvalid}); end
    total++; if (rr_s_req !== 1'b0) begin
      bad++; $display("FAIL reset_s_req got=%b want=0", rr_s_req); end
    total++; if (rr_outst !== 4'd0) begin
      bad++; $display("FAIL reset_outstanding got=%0d want=0", rr_outst); end
    total++; if ({rr_perr, rr_m0_err, rr_m1_err} !== 3'b000) begin
      bad++; $display("FAIL reset_perr_err got=%b want=000", {rr_perr, rr_m0_err, rr_m1_err}); end
    total++; if ({fp_s_req, fp_m0_gnt, fp_m1_gnt, fp_outst} !== 7'b0) begin
      bad++; $display("FAIL reset_fp got=%b want=0", {fp_s_req, fp_m0_gnt, fp_m1_gnt, fp_outst}); end
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h100; m0_we = 1'b0; s_gnt = 1'b1;
    #4;
    total++; if ({rr_m1_gnt, rr_m0_gnt} !== 2'b01) begin
      bad++; $display("FAIL single_gnt got=%b want=01", {rr_m1_gnt, rr_m0_gnt}); end
    total++; if (rr_s_req !== 1'b1 || rr_s_addr !== 32'h100) begin
      bad++; $display("FAIL single_s_addr got=%b/%h want=1/00000100", rr_s_req, rr_s_addr); end
    next_cycle();
    m0_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
    #4;
    total++; if ({rr_m1_rvalid, rr_m0_rvalid} !== 2'b01) begin
      bad++; $display("FAIL single_rvalid got=%b want=01", {rr_m1_rvalid, rr_m0_rvalid}); end
    total++; if (rr_m0_rdata !== 32'hDEADBEEF || rr_m0_err !== 1'b0) begin
      bad++; $display("FAIL single_rdata got=%h/%b want=deadbeef/0", rr_m0_rdata, rr_m0_err); end
    total++; if (rr_outst !== 4'd1) begin
      bad++; $display("FAIL single_outst_before_pop got=%0d want=1", rr_outst); end
    next_cycle();
    s_rvalid = 1'b0;
    #4;
    total++; if (rr_outst !== 4'd0 || rr_m0_rvalid !== 1'b0) begin
      bad++; $display("FAIL single_drained got=%0d/%b want=0/0", rr_outst, rr_m0_rvalid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_seq;
    rr_seq = 4'b1010;   // bit i = master granted in cycle i: m0,m1,m0,m1
    do_reset();
    next_cycle();
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h10; m1_addr = 32'h20; s_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = (i > 0); s_rdata = 32'h1000 + i;
      #4;
      total++; if ({rr_m1_gnt, rr_m0_gnt} !== {rr_seq[i], ~rr_seq[i]}) begin
        bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", i, {rr_m1_gnt, rr_m0_gnt}, {rr_seq[i], ~rr_seq[i]}); end
      total++; if ({fp_m1_gnt, fp_m0_gnt} !== 2'b01) begin
        bad++; $display("FAIL fixed_grant[%0d] got=%b want=01", i, {fp_m1_gnt, fp_m0_gnt}); end
      if (i > 0) begin
        total++; if ({rr_m1_rvalid, rr_m0_rvalid} !== {rr_seq[i-1], ~rr_seq[i-1]}) begin
          bad++; $display("FAIL rr_route[%0d] got=%b want=%b", i, {rr_m1_rvalid, rr_m0_rvalid}, {rr_seq[i-1], ~rr_seq[i-1]}); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h200; m1_we = 1'b1; m1_be = 4'h3; m1_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin m0_req = 1'b1; m0_addr = 32'h300; end
      #4;
      total++; if (rr_s_req !== 1'b1 || rr_s_addr !== 32'h200 || fp_s_addr !== 32'h200) begin
        bad++; $display("FAIL hold_addr[%0d] got=%b/%h/%h want=1/200/200", i, rr_s_req, rr_s_addr, fp_s_addr); end
      total++; if ({rr_m0_gnt, rr_m1_gnt, fp_m0_gnt, fp_m1_gnt} !== 4'b0000) begin
        bad++; $display("FAIL hold_nogrant[%0d] got=%b want=0000", i, {rr_m0_gnt, rr_m1_gnt, fp_m0_gnt, fp_m1_gnt}); end
      if (i == 0) begin
        total++; if ({rr_s_we, rr_s_be, rr_s_wdata} !== {1'b1, 4'h3, 32'hCAFEF00D}) begin
          bad++; $display("FAIL hold_wr_fields got=%b/%h/%h want=1/3/cafef00d", rr_s_we, rr_s_be, rr_s_wdata); end
      end
      next_cycle();
    end
    s_gnt = 1'b1;
    #4;
    total++; if ({rr_m1_gnt, rr_m0_gnt, fp_m1_gnt, fp_m0_gnt} !== 4'b1010) begin
      bad++; $display("FAIL hold_first_m1 got=%b want=1010", {rr_m1_gnt, rr_m0_gnt, fp_m1_gnt, fp_m0_gnt}); end
    next_cycle();
    m1_req = 1'b0;
    #4;
    total++; if ({rr_m1_gnt, rr_m0_gnt, fp_m1_gnt, fp_m0_gnt} !== 4'b0101 || rr_s_addr !== 32'h300) begin
      bad++; $display("FAIL hold_then_m0 got=%b/%h want=0101/300", {rr_m1_gnt, rr_m0_gnt, fp_m1_gnt, fp_m0_gnt}, rr_s_addr); end
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    next_cycle();
    m0_req = 1'b1; s_gnt = 1'b1;                                   // cycle 0: m0 granted
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b1;                                  // cycle 1: m1 granted
    next_cycle();
    m0_req = 1'b1; m1_req = 1'b0;                                  // cycle 2: full
    #4;
    total++; if (rr_outst !== 4'd2 || rr_s_req !== 1'b0 || rr_m0_gnt !== 1'b0) begin
      bad++; $display("FAIL full_block got=%0d/%b/%b want=2/0/0", rr_outst, rr_s_req, rr_m0_gnt); end
    next_cycle();
    s_rvalid = 1'b1; s_rdata = 32'hA;                               // cycle 3: pop, push still blocked
    #4;
    total++; if ({rr_m1_rvalid, rr_m0_rvalid} !== 2'b01 || rr_s_req !== 1'b0) begin
      bad++; $display("FAIL full_pop_same_cycle got=%b/%b want=01/0", {rr_m1_rvalid, rr_m0_rvalid}, rr_s_req); end
    next_cycle();
    s_rvalid = 1'b0;                                               // cycle 4: reissue
    #4;
    total++; if (rr_outst !== 4'd1 || rr_s_req !== 1'b1 || rr_m0_gnt !== 1'b1) begin
      bad++; $display("FAIL full_reissue got=%0d/%b/%b want=1/1/1", rr_outst, rr_s_req, rr_m0_gnt); end
    next_cycle();
    m0_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hB; s_err = 1'b1;
    #4;
    total++; if ({rr_m1_rvalid, rr_m0_rvalid} !== 2'b10 || rr_m1_rdata !== 32'hB || {rr_m1_err, rr_m0_err} !== 2'b10) begin
      bad++; $display("FAIL full_order_m1 got=%b/%h/%b want=10/b/10", {rr_m1_rvalid, rr_m0_rvalid}, rr_m1_rdata, {rr_m1_err, rr_m0_err}); end
    next_cycle();
    s_rdata = 32'hC; s_err = 1'b0;
    #4;
    total++; if ({rr_m1_rvalid, rr_m0_rvalid} !== 2'b01 || rr_outst !== 4'd1) begin
      bad++; $display("FAIL full_order_m0 got=%b/%0d want=01/1", {rr_m1_rvalid, rr_m0_rvalid}, rr_outst); end
    next_cycle();
    s_rvalid = 1'b0;
    #4;
    total++; if (rr_outst !== 4'd0 || rr_perr !== 1'b0) begin
      bad++; $display("FAIL full_drained got=%0d/%b want=0/0", rr_outst, rr_perr); end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    next_cycle();
    m0_req = 1'b1; s_gnt = 1'b1;                                   // leave one request in flight
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;                                                  // reset mid-transfer
    #2;
    rst_n = 1'b1;
    next_cycle();
    s_rvalid = 1'b1; s_rdata = 32'h55;                              // response to a discarded ID
    #4;
    total++; if ({rr_m1_rvalid, rr_m0_rvalid, fp_m1_rvalid, fp_m0_rvalid} !== 4'b0000) begin
      bad++; $display("FAIL spurious_rvalid got=%b want=0000", {rr_m1_rvalid, rr_m0_rvalid, fp_m1_rvalid, fp_m0_rvalid}); end
    total++; if (rr_perr !== 1'b0) begin
      bad++; $display("FAIL spurious_perr_early got=%b want=0", rr_perr); end
    next_cycle();
    s_rvalid = 1'b0;
    repeat (3) next_cycle();
    #4;
    total++; if (rr_perr !== 1'b1 || fp_perr !== 1'b1) begin
      bad++; $display("FAIL spurious_perr_sticky got=%b/%b want=1/1", rr_perr, fp_perr); end
    rst_n = 1'b0;
    #2;
    total++; if (rr_perr !== 1'b0) begin
      bad++; $display("FAIL spurious_perr_cleared got=%b want=0", rr_perr); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Random traffic on the round-robin instance against a queue-based model.
  task automatic test_random();
    bit q[$];
    bit hold, hsel, rr, sel, want, full, exp_req, popped;
    logic [1:0] exp_rv;
    do_reset();
    hold = 0; hsel = 0; rr = 0;
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      m0_req = ($urandom_range(0, 3) != 0); m1_req = ($urandom_range(0, 3) != 0);
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_be = 4'($urandom); m1_be = 4'($urandom);
      s_gnt = $urandom_range(0, 1);
      s_rvalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      s_rdata = $urandom; s_err = $urandom_range(0, 1);
      #4;
      full = (q.size() == DEPTH);
      if (hold) begin sel = hsel; want = hsel ? m1_req : m0_req; end
      else if (m0_req && m1_req) begin sel = rr; want = 1; end
      else begin sel = m1_req; want = m0_req || m1_req; end
      exp_req = want && !full;
      popped = s_rvalid && (q.size() > 0);
      exp_rv = popped ? (q[0] ? 2'b10 : 2'b01) : 2'b00;
      total++; if (rr_s_req !== exp_req) begin
        bad++; $display("FAIL rand_s_req[%0d] got=%b want=%b", c, rr_s_req, exp_req); end
      total++; if ({rr_m1_gnt, rr_m0_gnt} !== {exp_req && s_gnt && sel, exp_req && s_gnt && !sel}) begin
        bad++; $display("FAIL rand_gnt[%0d] got=%b want=%b", c, {rr_m1_gnt, rr_m0_gnt}, {exp_req && s_gnt && sel, exp_req && s_gnt && !sel}); end
      if (exp_req) begin
        total++; if ({rr_s_addr, rr_s_we, rr_s_be, rr_s_wdata} !== (sel ? {m1_addr, m1_we, m1_be, m1_wdata} : {m0_addr, m0_we, m0_be, m0_wdata})) begin
          bad++; $display("FAIL rand_s_fields[%0d] got=%h want_master=%0d", c, {rr_s_addr, rr_s_we, rr_s_be, rr_s_wdata}, sel); end
      end
      total++; if ({rr_m1_rvalid, rr_m0_rvalid} !== exp_rv) begin
        bad++; $display("FAIL rand_rvalid[%0d] got=%b want=%b", c, {rr_m1_rvalid, rr_m0_rvalid}, exp_rv); end
      total++; if ({rr_m1_err, rr_m0_err} !== (exp_rv & {2{s_err}}) || rr_m0_rdata !== s_rdata || rr_m1_rdata !== s_rdata) begin
        bad++; $display("FAIL rand_rdata_err[%0d] got=%b/%h/%h want=%b/%h", c, {rr_m1_err, rr_m0_err}, rr_m0_rdata, rr_m1_rdata, exp_rv & {2{s_err}}, s_rdata); end
      total++; if (rr_outst !== 4'(q.size()) || rr_perr !== 1'b0) begin
        bad++; $display("FAIL rand_outst_perr[%0d] got=%0d/%b want=%0d/0", c, rr_outst, rr_perr, q.size()); end
      if (popped) void'(q.pop_front());
      if (exp_req && s_gnt) begin
        q.push_back(sel); rr = !sel; hold = 0;
      end else if (hold && !want) begin
        hold = 0;
      end else if (!hold && exp_req) begin
        hold = 1; hsel = sel;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold();
    test_fifo_full();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_port_arbiter
`default_nettype wire

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
Shares the single data-memory port between two requesters: master 0 is the core LSU and master 1 is the trace/debug access port. Both masters and the memory use the req/gnt address phase followed by an rvalid response phase. The block arbitrates the address phase and holds the arbitration decision until it is granted. It records the ID of every accepted request in an in-order FIFO and routes each rvalid/rdata/err back to the master that issued it. It sits between the core/tracer and data_memory.

Parameters:
MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO; legal range 1..8.
ARB_MODE, 1, 0 = fixed priority (master 0 wins), 1 = round-robin.
ADDR_WIDTH, 32, address width.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
m0_req_i / m1_req_i  in  1  master request
m0_addr_i / m1_addr_i  in  ADDR_WIDTH  master address
m0_we_i / m1_we_i  in  1  write enable
m0_be_i / m1_be_i  in  4  byte enables
m0_wdata_i / m1_wdata_i  in  32  write data
m0_gnt_o / m1_gnt_o  out  1  address-phase grant
m0_rvalid_o / m1_rvalid_o  out  1  response valid
m0_rdata_o / m1_rdata_o  out  32  response data
m0_err_o / m1_err_o  out  1  response error
s_req_o  out  1  memory request
s_addr_o  out  ADDR_WIDTH  memory address
s_we_o  out  1  memory write enable
s_be_o  out  4  memory byte enables
s_wdata_o  out  32  memory write data
s_gnt_i  in  1  memory grant
s_rvalid_i  in  1  memory response valid
s_rdata_i  in  32  memory read data
s_err_i  in  1  memory error
outstanding_o  out  4  count of accepted requests not yet answered
protocol_err_o  out  1  sticky flag: rvalid arrived with no outstanding request

Behaviour:
- Reset (async, rst_ni=0):
  - FIFO empty; outstanding_o=0; protocol_err_o=0.
  - Arbiter state IDLE; round-robin pointer rr_next=0.
  - All gnt/rvalid/err outputs 0; s_req_o=0.
- FSM states:
  - IDLE (no pending selection).
  - HOLD (selection sel latched, request issued but not yet granted).
- IDLE:
  - If any req_i is high and the FIFO is not full, choose sel combinationally.
  - Choice when both request: ARB_MODE=0 picks m0; ARB_MODE=1 picks rr_next.
  - Drive s_req_o=1 and mux sel's addr/we/be/wdata onto the s_* outputs.
  - If s_gnt_i=1 in the same cycle: the transfer completes with zero added latency and the FSM stays in IDLE.
  - If s_gnt_i=0: latch sel and move to HOLD.
- HOLD:
  - sel is frozen and s_* is driven from master sel.
  - The other master cannot preempt, so the memory-side request stays stable.
  - On s_gnt_i, return to IDLE.
  - If master sel drops req_i while in HOLD (protocol violation by that master), return to IDLE and set no flag.
- Grant: mX_gnt_o = s_gnt_i & s_req_o & (sel==X); this path is combinational.
- On grant:
  - Push sel into the FIFO.
  - In round-robin mode, set rr_next = ~sel.
- FIFO full (outstanding_o==MAX_OUTSTANDING):
  - s_req_o=0; no grant and no new selection.
  - An existing HOLD state is kept, but its request is masked.
  - A same-cycle pop does NOT unblock the push; this keeps the request path free of rvalid dependency.
- Response routing:
  - On s_rvalid_i with the FIFO non-empty, assert m{head}_rvalid_o=1.
  - rdata and err pass through combinationally to both masters; the rvalid of the non-head master is 0.
  - Pop the FIFO head.
- Simultaneous push and pop: count is unchanged, and pointers advance independently.
- s_rvalid_i while the FIFO is empty: no master sees rvalid; set protocol_err_o=1 until reset.
- Wrap-around: read/write pointers are modulo MAX_OUTSTANDING and the count is separate; outstanding_o is zero-extended.
- Reset mid-transfer: all in-flight IDs are discarded, and responses arriving after reset set protocol_err_o.

Decomposition:
- Package data_arb_pkg holds:
  - typedef master_id_t (1 bit);
  - enum arb_state_t {ARB_IDLE, ARB_HOLD};
  - ARB_FIXED / ARB_RR constants.
- One sub-module, id_fifo: a synchronous FIFO of master_id_t, parameterised depth, with push/pop/full/empty/count.

Test Plan:
- Reset: hold rst_ni=0 with m0_req_i=1 -> all gnt/rvalid=0, s_req_o=0, outstanding_o=0, protocol_err_o=0.
- Single read: m0 reads 0x100; memory grants same cycle; rvalid 1 cycle later with rdata 0xDEADBEEF -> m0_gnt_o at cycle 0; m0_rvalid_o with 0xDEADBEEF at cycle 1; m1_rvalid_o stays 0.
- Round-robin: both request continuously, s_gnt_i=1, ARB_MODE=1 -> grants alternate m0,m1,m0,m1; with ARB_MODE=0 -> m0 granted in all 4 cycles.
- HOLD stability: m1 requests 0x200 and s_gnt_i is held 0 for 3 cycles while m0 raises req -> s_addr_o stays 0x200 for all 3 cycles; m1 is granted first and m0 next.
- FIFO full, depth 2: two grants with no rvalid -> outstanding_o=2 and s_req_o=0. One rvalid -> outstanding_o=1 and the request reissues next cycle. Responses are routed in grant order (m0 then m1).
- Spurious rvalid: s_rvalid_i=1 with an empty FIFO -> no mX_rvalid_o; protocol_err_o=1 and it stays 1 until rst_ni=0.
